// File: rtl/led_blinker_pkg.sv
// rtl/led_blinker_pkg.sv - shared blink state encodings and timer sizing helpers
package led_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer must hold the larger phase length minus one; never narrower than one bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int w;
    w = $clog2(max_int(on_cycles, off_cycles));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_blinker_phase_timer.sv
// rtl/led_blinker_phase_timer.sv - loadable down-counter that holds at zero and flags done
module phase_timer #(
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - renders event pulses as ON/OFF LED blinks with a saturating replay queue
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_in,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int              TW       = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  blink_state_e     state_q, state_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W:0]   pend_sum;
  logic             req, consume;
  logic             timer_load, timer_done;
  logic [TW-1:0]    timer_val;

  phase_timer #(.TW(TW)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = ON_LOAD;
    consume    = 1'b0;
    req        = event_in | (pending_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_ON;
          timer_load = 1'b1;
          consume    = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_done) begin
          state_d    = ST_OFF;
          timer_load = 1'b1;
          timer_val  = OFF_LOAD;
        end
      end
      ST_OFF: begin
        // Queued requests chain straight into the next ON phase, no idle gap.
        if (timer_done) begin
          if (req) begin
            state_d    = ST_ON;
            timer_load = 1'b1;
            consume    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // consume implies req, so the subtraction never underflows the extended sum.
    pend_sum   = {1'b0, pending_q} + {{CNT_W{1'b0}}, event_in} - {{CNT_W{1'b0}}, consume};
    pending_d  = (pend_sum > {1'b0, PEND_MAX}) ? PEND_MAX : pend_sum[CNT_W-1:0];
    overflow_d = overflow_q | (event_in & ~consume & (pending_q == PEND_MAX));
    led_d      = (state_d == ST_ON);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
